// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM (Moore decode plus pcEn and the EXEC-state aluCtrl).
// Optional feature macro: MC_BNE_EN adds a BNE state (encoding 12) for bne instructions.
module mc_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcEn,
   output logic       iorD,
   output logic       memWrite,
   output logic       irWrite,
   output logic       regDst,
   output logic       memToReg,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] pcSrc,
   output logic [2:0] aluCtrl,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
`ifdef MC_BNE_EN
      , BNE  = 4'd12
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   state_t state_q;
   state_t state_d;
   logic   pc_write;
   logic   branch;
`ifdef MC_BNE_EN
   logic   branch_ne;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   // op is consumed combinationally in DECODE and MEMADR; it is never registered here.
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
`ifdef MC_BNE_EN
               OP_BNE:       state_d = BNE;
`endif
               default:      state_d = FETCH;
            endcase
         end
         MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         EXEC:   state_d = ALUWB;
         ADDIEX: state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      pc_write = 1'b0;
      branch   = 1'b0;
`ifdef MC_BNE_EN
      branch_ne = 1'b0;
`endif
      iorD     = 1'b0;
      memWrite = 1'b0;
      irWrite  = 1'b0;
      regDst   = 1'b0;
      memToReg = 1'b0;
      regWrite = 1'b0;
      aluSrcA  = 1'b0;
      aluSrcB  = 2'b00;
      pcSrc    = 2'b00;
      aluCtrl  = 3'b000;
      case (state_q)
         FETCH: begin
            irWrite  = 1'b1;
            pc_write = 1'b1;
            aluSrcB  = 2'b01;
         end
         DECODE: aluSrcB = 2'b11;
         MEMADR, ADDIEX: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
         end
         MEMRD: iorD = 1'b1;
         MEMWB: begin
            regWrite = 1'b1;
            memToReg = 1'b1;
         end
         MEMWR: begin
            iorD     = 1'b1;
            memWrite = 1'b1;
         end
         EXEC: begin
            aluSrcA = 1'b1;
            case (funct)
               6'b100000: aluCtrl = 3'b000;
               6'b100010: aluCtrl = 3'b001;
               6'b100100: aluCtrl = 3'b010;
               6'b100101: aluCtrl = 3'b011;
               default:   aluCtrl = 3'b111;
            endcase
         end
         ALUWB: begin
            regDst   = 1'b1;
            regWrite = 1'b1;
         end
         BRANCH: begin
            aluSrcA = 1'b1;
            aluCtrl = 3'b001;
            branch  = 1'b1;
            pcSrc   = 2'b01;
         end
`ifdef MC_BNE_EN
         BNE: begin
            aluSrcA   = 1'b1;
            aluCtrl   = 3'b001;
            branch_ne = 1'b1;
            pcSrc     = 2'b01;
         end
`endif
         ADDIWB: regWrite = 1'b1;
         JUMP: begin
            pc_write = 1'b1;
            pcSrc    = 2'b10;
         end
         default: ;
      endcase
   end

`ifdef MC_BNE_EN
   assign pcEn = pc_write | (branch & zero) | (branch_ne & ~zero);
`else
   assign pcEn = pc_write | (branch & zero);
`endif
   assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: per-instruction state plans plus a table of
// per-state output expectations; a directed reset-mid-EXEC check runs first.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
   logic [1:0] aluSrcB, pcSrc;
   logic [2:0] aluCtrl;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;
   int plan[$];

   mc_controller dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .pcEn(pcEn), .iorD(iorD), .memWrite(memWrite), .irWrite(irWrite),
      .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc),
      .aluCtrl(aluCtrl), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // {pcEn,iorD,memWrite,irWrite,regDst,memToReg,regWrite,aluSrcA,aluSrcB,pcSrc,aluCtrl}
   function automatic logic [14:0] pack(input logic pe, io, mw, iw, rd, m2r, rw, sa,
                                        input logic [1:0] sb, ps, input logic [2:0] ac);
      return {pe, io, mw, iw, rd, m2r, rw, sa, sb, ps, ac};
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      if (f == 6'b100000) return 3'b000;
      if (f == 6'b100010) return 3'b001;
      if (f == 6'b100100) return 3'b010;
      if (f == 6'b100101) return 3'b011;
      return 3'b111;
   endfunction

   function automatic logic [14:0] exp_outs(input int st, input logic [5:0] f, input logic z);
      case (st)
         0:    return pack(1,0,0,1,0,0,0,0, 2'b01, 2'b00, 3'b000);
         1:    return pack(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b000);
         2, 9: return pack(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b000);
         3:    return pack(0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000);
         4:    return pack(0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b000);
         5:    return pack(0,1,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000);
         6:    return pack(0,0,0,0,0,0,0,1, 2'b00, 2'b00, alu_of(f));
         7:    return pack(0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000);
         8:    return pack(z,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b001);
         10:   return pack(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b000);
         11:   return pack(1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000);
         12:   return pack(~z,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b001);
         default: return '0;
      endcase
   endfunction

   function automatic logic [14:0] dut_outs();
      return {pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA,
              aluSrcB, pcSrc, aluCtrl};
   endfunction

   // States an instruction visits after DECODE, by opcode.
   task automatic push_tail(input logic [5:0] o);
      case (o)
         6'b100011: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
         6'b101011: begin plan.push_back(2); plan.push_back(5); end
         6'b000000: begin plan.push_back(6); plan.push_back(7); end
         6'b000100: plan.push_back(8);
         6'b001000: begin plan.push_back(9); plan.push_back(10); end
         6'b000010: plan.push_back(11);
`ifdef MC_BNE_EN
         6'b000101: plan.push_back(12);
`endif
         default: ;
      endcase
   endtask

   function automatic logic [5:0] pick_op();
      logic [5:0] ops[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b000101, 6'b111111};
      int k = $urandom_range(0, 9);
      if (k < 8) return ops[k];
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic [5:0] pick_funct();
      logic [5:0] fs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      int k = $urandom_range(0, 5);
      if (k < 5) return fs[k];
      return 6'($urandom_range(0, 63));
   endfunction

   initial begin
      int cur;
      bit found;
      // Reset values while rst is held.
      #3;
      check("rst_state", 32'(state), 32'd0);
      check("rst_outs", 32'(dut_outs()), 32'(exp_outs(0, funct, zero)));
      @(negedge clk);
      rst = 1'b0;
      op  = 6'b000000;
      funct = 6'b100010;

      // Walk into EXEC, then pulse reset asynchronously.
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (state == 4'd6) found = 1'b1;
      end
      check("reach_exec", 32'(found), 32'd1);
      check("exec_aluctrl", 32'(aluCtrl), 32'b001);
      #1 rst = 1'b1;
      #1;
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_pcen", 32'(pcEn), 32'd1);
      check("async_rst_irwrite", 32'(irWrite), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("post_rst_hold", 32'(state), 32'd0);
      @(posedge clk);
      #1;
      check("post_rst_decode", 32'(state), 32'd1);

      // Random instruction stream; op is held for the life of each instruction.
      plan.push_back(1);
      for (int c = 0; c < 1500; c++) begin
         cur = plan[0];
         if (cur == 0) op = pick_op();
         funct = pick_funct();
         zero  = 1'($urandom_range(0, 1));
         @(negedge clk);
         check($sformatf("state_op%0h", op), 32'(state), 32'(cur));
         check($sformatf("outs_s%0d", cur), 32'(dut_outs()), 32'(exp_outs(cur, funct, zero)));
         void'(plan.pop_front());
         if (cur == 0) plan.push_back(1);
         else if (cur == 1) push_tail(op);
         if (plan.size() == 0) plan.push_back(0);
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
